// File: rtl/per2bpm.sv
// per2bpm: tap period to BPM via 24-step restoring divider (optional averaging with PER2BPM_AVG_EN)
module per2bpm #(
  parameter int PULSE_PER_NS = 5120,
  parameter int BPM_MAX      = 250,
  parameter int PER_W        = 17
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [PER_W-1:0] btn_per_i,
  input  logic             btn_per_valid_i,
  output logic [8:0]       bpm_o,
  output logic             bpm_valid_o,
  output logic             busy_o
);
  localparam logic [23:0] DIVIDEND = 24'(64'd60_000_000_000 / 64'(PULSE_PER_NS));
  localparam int DW = PER_W + 2;
  typedef enum logic [1:0] {IDLE, LOAD, DIV, DONE} state_t;
  state_t state_q, state_d;
  logic [PER_W-1:0] per_q, per_d, pend_q, pend_d;
  logic pend_v_q, pend_v_d;
  logic [DW-1:0] dv_q, dv_d, rem_q, rem_d, div_src;
  logic [DW:0] sh;
  logic ge;
  logic [23:0] quo_q, quo_d;
  logic [4:0] cnt_q, cnt_d;
  logic [8:0] bpm_q, bpm_d;
  logic vld_q, vld_d;
`ifdef PER2BPM_AVG_EN
  logic [3:0][PER_W-1:0] hist_q, hist_d;
  logic [2:0] fill_q, fill_d;
  logic [DW-1:0] sum;
  // history shifts on every LOAD; divisor switches to the average once four periods are in
  always_comb begin
    hist_d = (state_q == LOAD) ? {hist_q[2:0], per_q} : hist_q;
    fill_d = (state_q == LOAD && fill_q != 3'd4) ? fill_q + 3'd1 : fill_q;
    sum = DW'(hist_d[0]) + DW'(hist_d[1]) + DW'(hist_d[2]) + DW'(hist_d[3]);
    div_src = (fill_q >= 3'd3) ? sum >> 2 : DW'(per_q);
  end
  // averaging history registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end
`else
  assign div_src = DW'(per_q);
`endif
  assign sh = {rem_q, quo_q[23]};
  assign ge = sh >= {1'b0, dv_q};
  assign bpm_o = bpm_q;
  assign bpm_valid_o = vld_q;
  assign busy_o = state_q != IDLE;
  // sequencing, pending capture and one divider step per DIV cycle
  always_comb begin
    state_d = state_q;
    per_d = per_q;
    pend_d = pend_q;
    pend_v_d = pend_v_q;
    dv_d = dv_q;
    rem_d = rem_q;
    quo_d = quo_q;
    cnt_d = cnt_q;
    bpm_d = bpm_q;
    vld_d = 1'b0;
    if (btn_per_valid_i && state_q != IDLE) begin
      pend_d = btn_per_i;
      pend_v_d = 1'b1;
    end
    case (state_q)
      IDLE: if (btn_per_valid_i) begin
        per_d = btn_per_i;
        state_d = LOAD;
      end
      LOAD: begin
        dv_d = div_src;
        rem_d = '0;
        quo_d = DIVIDEND;
        cnt_d = 5'd24;
        state_d = DIV;
      end
      DIV: begin
        rem_d = ge ? DW'(sh - {1'b0, dv_q}) : DW'(sh);
        quo_d = {quo_q[22:0], ge};
        cnt_d = cnt_q - 5'd1;
        state_d = (cnt_q == 5'd1) ? DONE : DIV;
      end
      default: begin
        bpm_d = (quo_q > 24'(BPM_MAX)) ? 9'(BPM_MAX) : quo_q[8:0];
        vld_d = 1'b1;
        state_d = IDLE;
        if (btn_per_valid_i || pend_v_q) begin
          per_d = btn_per_valid_i ? btn_per_i : pend_q;
          pend_v_d = 1'b0;
          state_d = LOAD;
        end
      end
    endcase
  end
  // state registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      per_q <= '0;
      pend_q <= '0;
      pend_v_q <= 1'b0;
      dv_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      cnt_q <= '0;
      bpm_q <= '0;
      vld_q <= 1'b0;
    end else begin
      state_q <= state_d;
      per_q <= per_d;
      pend_q <= pend_d;
      pend_v_q <= pend_v_d;
      dv_q <= dv_d;
      rem_q <= rem_d;
      quo_q <= quo_d;
      cnt_q <= cnt_d;
      bpm_q <= bpm_d;
      vld_q <= vld_d;
    end
  end
endmodule

// File: tb/tb_per2bpm.sv
// tb_per2bpm: scoreboard bench for per2bpm (AVG sequence when PER2BPM_AVG_EN is defined)
module tb_per2bpm;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic [16:0] btn_per_i = '0;
  logic btn_per_valid_i = 1'b0;
  logic [8:0] bpm_o;
  logic bpm_valid_o;
  logic busy_o;
  typedef struct {
    logic [8:0] bpm;
    int cyc;
  } exp_t;
  exp_t exp_q[$];
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  logic prev_v = 1'b0;
  per2bpm dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .btn_per_i(btn_per_i),
    .btn_per_valid_i(btn_per_valid_i),
    .bpm_o(bpm_o),
    .bpm_valid_o(bpm_valid_o),
    .busy_o(busy_o)
  );
  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask
  task automatic strobe(input logic [16:0] p, output int e0);
    @(negedge clk_i);
    btn_per_i = p;
    btn_per_valid_i = 1'b1;
    e0 = cyc + 1;
    @(negedge clk_i);
    btn_per_valid_i = 1'b0;
  endtask
  task automatic expect_res(input logic [8:0] b, input int c);
    exp_t e;
    e.bpm = b;
    e.cyc = c;
    exp_q.push_back(e);
  endtask
  task automatic wait_empty();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    chk("result_timeout", 32'(exp_q.size()), 0);
    exp_q.delete();
  endtask
  always @(negedge clk_i) begin
    if (rst_i) prev_v = 1'b0;
    else begin
      if (bpm_valid_o !== 1'b0) begin
        chk("valid_width", 32'(prev_v), 0);
        if (exp_q.size() == 0) chk("unexpected_result", 32'(bpm_o), 0);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("bpm", 32'(bpm_o), 32'(e.bpm));
          chk("latency", 32'(cyc), 32'(e.cyc));
        end
      end
      prev_v = bpm_valid_o;
    end
  end
  initial begin
    int e0, e1, d;
    logic busy_ok;
    repeat (3) @(negedge clk_i);
    chk("rst_bpm", 32'(bpm_o), 0);
    chk("rst_valid", 32'(bpm_valid_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    rst_i = 1'b0;
`ifdef PER2BPM_AVG_EN
    strobe(17'd60000, e0);
    expect_res(9'd195, e0 + 26);
    wait_empty();
    strobe(17'd60000, e0);
    expect_res(9'd195, e0 + 26);
    wait_empty();
    strobe(17'd60000, e0);
    expect_res(9'd195, e0 + 26);
    wait_empty();
    strobe(17'd64000, e0);
    expect_res(9'd192, e0 + 26);
    wait_empty();
`else
    strobe(17'd62500, e0);
    expect_res(9'd187, e0 + 26);
    busy_ok = 1'b1;
    repeat (26) begin
      if (busy_o !== 1'b1) busy_ok = 1'b0;
      @(negedge clk_i);
    end
    chk("busy_during", 32'(busy_ok), 1);
    chk("busy_after", 32'(busy_o), 0);
    wait_empty();
    repeat (5) @(negedge clk_i);
    chk("bpm_hold", 32'(bpm_o), 187);
    strobe(17'd46875, e0);
    expect_res(9'd250, e0 + 26);
    wait_empty();
    strobe(17'd40000, e0);
    expect_res(9'd250, e0 + 26);
    wait_empty();
    strobe(17'd0, e0);
    expect_res(9'd250, e0 + 26);
    wait_empty();
    strobe(17'd62500, e0);
    expect_res(9'd187, e0 + 26);
    expect_res(9'd195, e0 + 52);
    repeat (4) @(negedge clk_i);
    strobe(17'd46875, d);
    repeat (6) @(negedge clk_i);
    strobe(17'd60000, d);
    wait_empty();
    repeat (5) @(negedge clk_i);
    chk("no_third", 32'(bpm_valid_o), 0);
    strobe(17'd46875, e0);
    expect_res(9'd250, e0 + 26);
    expect_res(9'd195, e0 + 52);
    repeat (24) @(negedge clk_i);
    strobe(17'd60000, e1);
    chk("done_strobe_edge", 32'(e1), 32'(e0 + 26));
    wait_empty();
    strobe(17'd62500, e0);
    repeat (10) @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("abort_bpm", 32'(bpm_o), 0);
    chk("abort_valid", 32'(bpm_valid_o), 0);
    chk("abort_busy", 32'(busy_o), 0);
    rst_i = 1'b0;
    repeat (40) @(negedge clk_i);
    chk("abort_idle_bpm", 32'(bpm_o), 0);
    strobe(17'd60000, e0);
    expect_res(9'd195, e0 + 26);
    wait_empty();
`endif
    repeat (3) @(negedge clk_i);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/per2bpm.md
PER2BPM -- requirements
Module: per2bpm

Interface
REQ-001 The block SHALL expose parameter PULSE_PER_NS, default 5120, time-pulse period in ns that defines the unit of btn_per_i.
REQ-002 The block SHALL expose parameter BPM_MAX, default 250, saturation ceiling of bpm_o.
REQ-003 The block SHALL expose parameter PER_W, default 17, width of btn_per_i.
REQ-004 The block SHALL derive localparam DIVIDEND = 60_000_000_000 / PULSE_PER_NS (11_718_750 at default), held in a 24-bit constant.
REQ-005 clk_i  input  1  single clock; all state on its rising edge.
REQ-006 rst_i  input  1  reset, asynchronous and active-high.
REQ-007 btn_per_i  input  PER_W  tap period in time-pulse units.
REQ-008 btn_per_valid_i  input  1  one-cycle strobe qualifying btn_per_i.
REQ-009 bpm_o  output  9  last computed tempo in BPM, held between results.
REQ-010 bpm_valid_o  output  1  one-cycle strobe when bpm_o is updated.
REQ-011 busy_o  output  1  high whenever the FSM is not in IDLE.

Function
REQ-012 The FSM SHALL have states IDLE, LOAD, DIV, DONE.
REQ-013 IDLE: on btn_per_valid_i=1, SHALL capture btn_per_i and go to LOAD.
REQ-014 LOAD (1 cycle): SHALL form the divisor, clear the remainder, load DIVIDEND, and set the iteration counter to 24.
REQ-015 DIV: SHALL perform one restoring shift-subtract step per cycle for exactly 24 cycles, then go to DONE.
REQ-016 DONE (1 cycle): SHALL register bpm_o = min(quotient, BPM_MAX), pulse bpm_valid_o, then go to IDLE, or to LOAD if a pending period is held.
REQ-017 Latency: btn_per_valid_i sampled at edge E0 from IDLE SHALL produce bpm_valid_o=1 in the cycle after edge E0+26, high for exactly one cycle.
REQ-018 Quotient SHALL be truncated (floor), with no rounding.
REQ-019 Divisor 0 SHALL run the same 26-cycle sequence; the all-ones quotient SHALL saturate to BPM_MAX.
REQ-020 A quotient above BPM_MAX SHALL output BPM_MAX; quotient width before saturation SHALL be 24 bits, with no overflow.
REQ-021 btn_per_valid_i while busy SHALL be stored in a one-deep pending register; a newer strobe SHALL overwrite an older pending value.
REQ-022 A pending period SHALL start in the cycle after DONE via LOAD, without returning to IDLE.
REQ-023 btn_per_valid_i in the same cycle as DONE SHALL be taken as pending and processed next.
REQ-024 bpm_o SHALL change only in DONE.

Reset
REQ-025 rst_i=1 SHALL force IDLE, bpm_o=0, bpm_valid_o=0, busy_o=0, pending cleared, divider registers and averaging history cleared.
REQ-026 Reset mid-division SHALL abort without emitting bpm_valid_o; the first result after release SHALL come only from a new strobe.

Configuration
REQ-027 Macro PER2BPM_AVG_EN SHALL select divisor averaging.
REQ-028 With PER2BPM_AVG_EN defined: a 4-entry period history SHALL shift in each accepted period in LOAD.
REQ-029 With PER2BPM_AVG_EN defined: the divisor SHALL be (sum of 4 entries) >> 2 using a 19-bit sum once 4 periods have been accepted since reset; before that, it SHALL be the latest period.
REQ-030 Without PER2BPM_AVG_EN: the history and fill counter SHALL be absent, and the divisor SHALL be the captured period.

Verification
REQ-031 Period 62500, AVG off -> bpm_o=187, bpm_valid_o one cycle, 26 clocks after strobe, busy_o high for the duration.
REQ-032 Periods 46875 then 40000 -> bpm_o=250, then 250 (292 saturated).
REQ-033 Period 0 -> bpm_o=250, with no X values and the same latency.
REQ-034 Strobes 62500, then 46875 and 60000 while busy -> exactly two results, 187 then 195; 46875 is dropped.
REQ-035 AVG on, periods 60000, 60000, 60000, 64000 -> fourth result uses divisor 61000, giving bpm_o=192.
REQ-036 rst_i pulsed at cycle 10 of a division -> no bpm_valid_o, bpm_o=0, busy_o=0 the cycle after the reset edge.
